// File: rtl/stdp_update_scheduler.sv
// Round-robin scheduler that feeds captured pre/post spike events and a periodic
// trace-decay request into one shared STDP update engine over a valid/ready port.
module stdp_update_scheduler #(
  parameter int N_SYN          = 8,
  parameter int IDX_W          = 3,
  parameter int DECAY_PERIOD   = 16,
  parameter int DECAY_MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_SYN-1:0] pre_spikes,
  input  logic [N_SYN-1:0] post_spikes,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [IDX_W-1:0] cmd_index,
  output logic             cmd_pre,
  output logic             cmd_post,
  output logic             cmd_decay,
  output logic [IDX_W:0]   pending_count,
  output logic [7:0]       overflow_count,
  output logic             busy
);
  localparam int DCNT_W = $clog2(DECAY_PERIOD);
  localparam int WAIT_W = $clog2(DECAY_MAX_WAIT + 2);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECAY_PERIOD - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(DECAY_MAX_WAIT);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_SYN - 1);

  // state | meaning
  // IDLE  | nothing offered ; ISSUE | payload held on cmd_* until cmd_ready
  typedef enum logic {IDLE, ISSUE} state_t;

  state_t             state_q, state_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [IDX_W-1:0]   cmd_index_q, cmd_index_d;
  logic               cmd_pre_q, cmd_pre_d;
  logic               cmd_post_q, cmd_post_d;
  logic               cmd_decay_q, cmd_decay_d;
  logic [N_SYN-1:0]   pend_pre_q, pend_pre_d;
  logic [N_SYN-1:0]   pend_post_q, pend_post_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic               decay_pending_q, decay_pending_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [7:0]         overflow_q, overflow_d;

  logic               accept, wrap, dec_clr, ev_ovf, dec_ovf;
  logic               dec_cand, found, pick_decay, decide;
  logic [N_SYN-1:0]   clr_pre, clr_post, pend_any, cand;
  logic [IDX_W-1:0]   win;
  logic [8:0]         ovf_sum;

  assign pend_any = pend_pre_q | pend_post_q;

  // Only the flags carried by the accepted command are cleared, so an event
  // that landed after the command was loaded stays pending for a later issue.
  always_comb begin
    accept   = cmd_valid_q && cmd_ready;
    clr_pre  = '0;
    clr_post = '0;
    if (accept && !cmd_decay_q) begin
      clr_pre[cmd_index_q]  = cmd_pre_q;
      clr_post[cmd_index_q] = cmd_post_q;
    end
    pend_pre_d  = (pend_pre_q & ~clr_pre) | pre_spikes;
    pend_post_d = (pend_post_q & ~clr_post) | post_spikes;
    ev_ovf = |((pre_spikes & pend_pre_q & ~clr_pre) |
               (post_spikes & pend_post_q & ~clr_post));

    wrap            = (dcnt_q == DCNT_LAST);
    dcnt_d          = wrap ? '0 : dcnt_q + 1'b1;
    dec_clr         = accept && cmd_decay_q;
    decay_pending_d = (decay_pending_q && !dec_clr) || wrap;
    dec_ovf         = wrap && decay_pending_q && !dec_clr;

    ovf_sum    = {1'b0, overflow_q} + {8'b0, ev_ovf} + {8'b0, dec_ovf};
    overflow_d = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
  end

  always_comb begin
    int j;
    cand = pend_any;
    if (state_q == ISSUE && !cmd_decay_q) cand[cmd_index_q] = 1'b0;
    dec_cand = decay_pending_q && !(state_q == ISSUE && cmd_decay_q);
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 0; k < N_SYN; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N_SYN) j = j - N_SYN;
      if (!found && cand[IDX_W'(j)]) begin
        found = 1'b1;
        win   = IDX_W'(j);
      end
    end
    pick_decay = dec_cand && (!found || wait_q >= WAIT_MAX);
    decide     = enable && (found || dec_cand) && (state_q == IDLE || accept);
  end

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_index_d = cmd_index_q;
    cmd_pre_d   = cmd_pre_q;
    cmd_post_d  = cmd_post_q;
    cmd_decay_d = cmd_decay_q;
    rr_ptr_d    = rr_ptr_q;
    wait_d      = wait_q;
    if (decide) begin
      state_d     = ISSUE;
      cmd_valid_d = 1'b1;
      if (pick_decay) begin
        cmd_index_d = '0;
        cmd_pre_d   = 1'b0;
        cmd_post_d  = 1'b0;
        cmd_decay_d = 1'b1;
        wait_d      = '0;
      end else begin
        cmd_index_d = win;
        cmd_pre_d   = pend_pre_q[win];
        cmd_post_d  = pend_post_q[win];
        cmd_decay_d = 1'b0;
        rr_ptr_d    = (win == IDX_LAST) ? '0 : win + 1'b1;
        if (dec_cand && wait_q < WAIT_MAX) wait_d = wait_q + 1'b1;
      end
    end else if (accept) begin
      state_d     = IDLE;
      cmd_valid_d = 1'b0;
      cmd_index_d = '0;
      cmd_pre_d   = 1'b0;
      cmd_post_d  = 1'b0;
      cmd_decay_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cmd_valid_q     <= 1'b0;
      cmd_index_q     <= '0;
      cmd_pre_q       <= 1'b0;
      cmd_post_q      <= 1'b0;
      cmd_decay_q     <= 1'b0;
      pend_pre_q      <= '0;
      pend_post_q     <= '0;
      rr_ptr_q        <= '0;
      dcnt_q          <= '0;
      decay_pending_q <= 1'b0;
      wait_q          <= '0;
      overflow_q      <= '0;
    end else begin
      state_q         <= state_d;
      cmd_valid_q     <= cmd_valid_d;
      cmd_index_q     <= cmd_index_d;
      cmd_pre_q       <= cmd_pre_d;
      cmd_post_q      <= cmd_post_d;
      cmd_decay_q     <= cmd_decay_d;
      pend_pre_q      <= pend_pre_d;
      pend_post_q     <= pend_post_d;
      rr_ptr_q        <= rr_ptr_d;
      dcnt_q          <= dcnt_d;
      decay_pending_q <= decay_pending_d;
      wait_q          <= wait_d;
      overflow_q      <= overflow_d;
    end
  end

  always_comb begin
    pending_count = '0;
    for (int k = 0; k < N_SYN; k++)
      pending_count = pending_count + {{IDX_W{1'b0}}, pend_any[k]};
  end

  assign cmd_valid      = cmd_valid_q;
  assign cmd_index      = cmd_index_q;
  assign cmd_pre        = cmd_pre_q;
  assign cmd_post       = cmd_post_q;
  assign cmd_decay      = cmd_decay_q;
  assign overflow_count = overflow_q;
  assign busy           = cmd_valid_q | (|pend_any) | decay_pending_q;

endmodule
